mem_stage_vlsu_ctrl: RTL and testbench

- Memory-stage controller between the simd_processor MEM stage and vector_load_store_unit.
- Converts a single-cycle MEM-stage request into a held, one-shot transaction on the VLSU.
- Stalls the pipeline while the VLSU is busy, and registers load results for writeback.
- Flags misaligned vector accesses and VLSU hang (timeout).

---
 rtl/mem_stage_vlsu_ctrl_pkg.sv | 31 +++
 rtl/mem_stage_vlsu_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem_stage_vlsu_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_vlsu_ctrl_pkg.sv
// Shared types for the MEM-stage / vector load-store unit handshake:
// controller states, the captured request record and the vector alignment helper.
package mem_pkg;

    localparam int MEM_ADDR_W     = 32;
    localparam int MEM_SDATA_W    = 16;
    localparam int MEM_VDATA_W    = 256;
    localparam int VEC_BYTES      = 32;
    localparam int VEC_ALIGN_BITS = $clog2(VEC_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic                   write;
        logic                   vec;
        logic [MEM_ADDR_W-1:0]  addr;
        logic [MEM_SDATA_W-1:0] sdata;
        logic [MEM_VDATA_W-1:0] vdata;
    } mem_req_t;

    // A vector access must start on a full 32-byte line.
    function automatic logic vec_misaligned(input logic [MEM_ADDR_W-1:0] addr);
        return (addr[VEC_ALIGN_BITS-1:0] != {VEC_ALIGN_BITS{1'b0}});
    endfunction

endpackage

// File: rtl/mem_stage_vlsu_ctrl.sv
// MEM-stage controller: turns a one-cycle MEM request into a held, single-strobe VLSU
// transaction, stalls the pipeline meanwhile and registers load results for writeback.
module mem_stage_vlsu_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int SDATA_W      = 16,
    parameter int VDATA_W      = 256,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_valid_i,
    input  logic               mem_write_i,
    input  logic               mem_vec_i,
    input  logic [ADDR_W-1:0]  mem_addr_i,
    input  logic [SDATA_W-1:0] mem_sdata_i,
    input  logic [VDATA_W-1:0] mem_vdata_i,
    output logic               stall_o,
    output logic [31:0]        rdata_o,
    output logic [VDATA_W-1:0] vrdata_o,
    output logic               err_align_o,
    output logic               err_timeout_o,
    output logic               vlsu_req_o,
    output logic               vlsu_write_o,
    output logic               vlsu_src_o,
    output logic [ADDR_W-1:0]  vlsu_addr_o,
    output logic [SDATA_W-1:0] vlsu_sdata_o,
    output logic [VDATA_W-1:0] vlsu_vdata_o,
    input  logic               vlsu_busy_i,
    input  logic [SDATA_W-1:0] vlsu_sdata_i,
    input  logic [VDATA_W-1:0] vlsu_vdata_i
);

    localparam int               CNT_W    = $clog2(BUSY_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    mem_state_t         state_r;
    mem_state_t         state_nxt_s;
    mem_req_t           req_r;
    logic [CNT_W-1:0]   wait_cnt_r;
    logic [SDATA_W-1:0] rdata_r;
    logic [VDATA_W-1:0] vrdata_r;
    logic               err_align_r;
    logic               err_timeout_r;

    logic               stall_s;
    logic               capture_s;
    logic               load_done_s;
    logic               set_align_s;
    logic               set_timeout_s;
    logic               drive_s;

    // State register; reset drops straight back to IDLE, which also kills any strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode plus the per-state control strobes.
    always_comb begin
        state_nxt_s   = state_r;
        stall_s       = 1'b0;
        capture_s     = 1'b0;
        load_done_s   = 1'b0;
        set_align_s   = 1'b0;
        set_timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                stall_s = mem_valid_i;
                if (mem_valid_i) begin
                    capture_s = 1'b1;
                    if (mem_vec_i && vec_misaligned(mem_addr_i)) begin
                        set_align_s = 1'b1;
                        state_nxt_s = RESP;
                    end else begin
                        state_nxt_s = ISSUE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                stall_s     = 1'b1;
                state_nxt_s = WAIT;
            end
            WAIT: begin
                stall_s = 1'b1;
                // Busy is not trusted in the cycle right after the strobe.
                if (!vlsu_busy_i && (wait_cnt_r >= CNT_ONE)) begin
                    load_done_s = ~req_r.write;
                    state_nxt_s = RESP;
                end else if (wait_cnt_r >= TMO_LAST) begin
                    set_timeout_s = 1'b1;
                    state_nxt_s   = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Request capture, wait counter, load result registers and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_r         <= '0;
            wait_cnt_r    <= {CNT_W{1'b0}};
            rdata_r       <= {SDATA_W{1'b0}};
            vrdata_r      <= {VDATA_W{1'b0}};
            err_align_r   <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            if (capture_s) begin
                req_r.write <= mem_write_i;
                req_r.vec   <= mem_vec_i;
                req_r.addr  <= mem_addr_i;
                req_r.sdata <= mem_sdata_i;
                req_r.vdata <= mem_vdata_i;
            end
            if (state_r == WAIT) begin
                wait_cnt_r <= wait_cnt_r + CNT_ONE;
            end else begin
                wait_cnt_r <= {CNT_W{1'b0}};
            end
            if (load_done_s) begin
                if (req_r.vec) begin
                    vrdata_r <= vlsu_vdata_i;
                end else begin
                    rdata_r <= vlsu_sdata_i;
                end
            end
            if (set_align_s) begin
                err_align_r <= 1'b1;
            end
            if (set_timeout_s) begin
                err_timeout_r <= 1'b1;
            end
        end
    end

    // VLSU command lines only carry the request while the transaction is in flight.
    assign drive_s       = (state_r == ISSUE) || (state_r == WAIT);
    assign vlsu_req_o    = (state_r == ISSUE);
    assign vlsu_write_o  = drive_s & req_r.write;
    assign vlsu_src_o    = drive_s & req_r.vec;
    assign vlsu_addr_o   = drive_s ? req_r.addr  : {ADDR_W{1'b0}};
    assign vlsu_sdata_o  = drive_s ? req_r.sdata : {SDATA_W{1'b0}};
    assign vlsu_vdata_o  = drive_s ? req_r.vdata : {VDATA_W{1'b0}};

    assign stall_o       = stall_s;
    assign rdata_o       = {{(32-SDATA_W){1'b0}}, rdata_r};
    assign vrdata_o      = vrdata_r;
    assign err_align_o   = err_align_r;
    assign err_timeout_o = err_timeout_r;

endmodule

// File: tb/tb_mem_stage_vlsu_ctrl.sv
// Bench for mem_stage_vlsu_ctrl: directed scenarios followed by random transactions,
// each checked cycle by cycle against an arithmetic timing model of the handshake.
module tb_mem_stage_vlsu_ctrl;

    localparam int T = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_valid_i, mem_write_i, mem_vec_i;
    logic [31:0]  mem_addr_i;
    logic [15:0]  mem_sdata_i;
    logic [255:0] mem_vdata_i;
    logic         stall_o;
    logic [31:0]  rdata_o;
    logic [255:0] vrdata_o;
    logic         err_align_o, err_timeout_o;
    logic         vlsu_req_o, vlsu_write_o, vlsu_src_o;
    logic [31:0]  vlsu_addr_o;
    logic [15:0]  vlsu_sdata_o;
    logic [255:0] vlsu_vdata_o;
    logic         vlsu_busy_i;
    logic [15:0]  vlsu_sdata_i;
    logic [255:0] vlsu_vdata_i;

    int checks = 0;
    int errors = 0;
    int cyc_g = 0;
    int last_req = -100;

    // Reference state kept by the bench
    logic [31:0]  exp_rdata;
    logic [255:0] exp_vrdata;
    logic         exp_align;
    logic         exp_tmo;

    always #5 clk = ~clk;

    mem_stage_vlsu_ctrl #(.BUSY_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .mem_valid_i(mem_valid_i), .mem_write_i(mem_write_i), .mem_vec_i(mem_vec_i),
        .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i), .mem_vdata_i(mem_vdata_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .vrdata_o(vrdata_o),
        .err_align_o(err_align_o), .err_timeout_o(err_timeout_o),
        .vlsu_req_o(vlsu_req_o), .vlsu_write_o(vlsu_write_o), .vlsu_src_o(vlsu_src_o),
        .vlsu_addr_o(vlsu_addr_o), .vlsu_sdata_o(vlsu_sdata_o), .vlsu_vdata_o(vlsu_vdata_o),
        .vlsu_busy_i(vlsu_busy_i), .vlsu_sdata_i(vlsu_sdata_i), .vlsu_vdata_i(vlsu_vdata_i)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc_g++;
    endtask

    task automatic chk_state(input string pfx);
        chk({pfx, "_rdata"},  rdata_o,       exp_rdata);
        chk({pfx, "_vrdata"}, vrdata_o,      exp_vrdata);
        chk({pfx, "_ealign"}, err_align_o,   exp_align);
        chk({pfx, "_etmo"},   err_timeout_o, exp_tmo);
    endtask

    // One MEM request. VLSU busy is high from the strobe cycle for k cycles.
    // Relative cycles: 0 = IDLE accept, 1 = strobe, exit at c = max(3, k+1),
    // or timeout at T+1 when busy outlasts that; RESP at c+1.
    task automatic run_txn(input string tag, input logic wr, input logic vec,
                           input logic [31:0] addr, input logic [15:0] sd,
                           input logic [255:0] vd, input int k,
                           input logic [15:0] rs, input logic [255:0] rv,
                           input logic follows);
        logic mis;
        int   c, resp;
        mis = vec && (addr[4:0] != 5'd0);
        if (mis)         c = 0;
        else if (k <= T) c = (k + 1 > 3) ? k + 1 : 3;
        else             c = T + 1;
        resp = c + 1;
        for (int cyc = 0; cyc <= resp; cyc++) begin
            if (cyc == 0) begin
                mem_valid_i = 1'b1; mem_write_i = wr; mem_vec_i = vec;
                mem_addr_i = addr; mem_sdata_i = sd; mem_vdata_i = vd;
            end else begin
                mem_valid_i = (cyc < resp) || follows;
                mem_write_i = 1'($urandom); mem_vec_i = 1'($urandom);
                mem_addr_i = $urandom; mem_sdata_i = 16'($urandom); mem_vdata_i = rnd256();
            end
            vlsu_busy_i = !mis && cyc >= 1 && cyc <= k;
            if (!mis && cyc == c && k <= T) begin
                vlsu_sdata_i = rs; vlsu_vdata_i = rv;
            end else begin
                vlsu_sdata_i = 16'($urandom); vlsu_vdata_i = rnd256();
            end
            if (cyc == resp) begin
                if (mis) exp_align = 1'b1;
                else if (k > T) exp_tmo = 1'b1;
                else if (!wr && vec) exp_vrdata = rv;
                else if (!wr) exp_rdata = {16'h0000, rs};
            end
            #1;
            chk({tag, "_stall"}, stall_o, (cyc < resp));
            chk({tag, "_req"}, vlsu_req_o, (!mis && cyc == 1));
            if (vlsu_req_o) begin
                if (last_req >= 0) chk({tag, "_reqgap"}, (cyc_g - last_req >= 4), 1'b1);
                last_req = cyc_g;
            end
            if (!mis && cyc >= 1 && cyc <= c) begin
                chk({tag, "_vwrite"}, vlsu_write_o, wr);
                chk({tag, "_vsrc"},   vlsu_src_o,   vec);
                chk({tag, "_vaddr"},  vlsu_addr_o,  addr);
                chk({tag, "_vsdata"}, vlsu_sdata_o, sd);
                chk({tag, "_vvdata"}, vlsu_vdata_o, vd);
            end else if (cyc == 0) begin
                chk({tag, "_idle_cmd"}, {vlsu_write_o, vlsu_src_o, vlsu_addr_o, vlsu_sdata_o},
                    {1'b0, 1'b0, 32'h0, 16'h0});
                chk({tag, "_idle_vdata"}, vlsu_vdata_o, 256'h0);
            end
            chk_state(tag);
            step();
        end
        mem_valid_i = 1'b0;
        vlsu_busy_i = 1'b0;
    endtask

    logic [255:0] lanes;
    logic [255:0] vpat;

    initial begin
        reset = 1'b1;
        mem_valid_i = 1'b0; mem_write_i = 1'b0; mem_vec_i = 1'b0;
        mem_addr_i = 32'h0; mem_sdata_i = 16'h0; mem_vdata_i = 256'h0;
        vlsu_busy_i = 1'b0; vlsu_sdata_i = 16'h0; vlsu_vdata_i = 256'h0;
        exp_rdata = 32'h0; exp_vrdata = 256'h0; exp_align = 1'b0; exp_tmo = 1'b0;
        for (int i = 0; i < 16; i++) lanes[16*i +: 16] = 16'(i + 1);

        // Reset state
        #12;
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_req", vlsu_req_o, 1'b0);
        chk("rst_vaddr", vlsu_addr_o, 32'h0);
        chk_state("rst");
        reset = 1'b0;
        step();

        run_txn("sload", 1'b0, 1'b0, 32'h40, 16'h1234, 256'h0, 3, 16'hBEEF, 256'h0, 1'b0);
        chk("sload_rdata_abs", rdata_o, 32'h0000BEEF);
        run_txn("vstore", 1'b1, 1'b1, 32'h60, 16'h5555, lanes, 2, 16'hDEAD, rnd256(), 1'b0);
        chk("vstore_vrdata_abs", vrdata_o, 256'h0);
        run_txn("misalign", 1'b0, 1'b1, 32'h64, 16'h0, 256'h0, 3, 16'h0, rnd256(), 1'b0);
        chk("misalign_flag_abs", err_align_o, 1'b1);
        run_txn("hang", 1'b0, 1'b0, 32'h80, 16'h0, 256'h0, 20, 16'h7777, 256'h0, 1'b0);
        chk("hang_flag_abs", err_timeout_o, 1'b1);
        chk("hang_idle_stall", stall_o, 1'b0);
        step();

        // Back-to-back with mem_valid_i held through RESP
        vpat = rnd256();
        run_txn("b2b_st", 1'b1, 1'b0, 32'h100, 16'hA5A5, 256'h0, 1, 16'h0, 256'h0, 1'b1);
        run_txn("b2b_ld", 1'b0, 1'b1, 32'h120, 16'h0, 256'h0, 4, 16'h0, vpat, 1'b0);
        chk("b2b_vrdata_abs", vrdata_o, vpat);

        // Reset during WAIT
        mem_valid_i = 1'b1; mem_write_i = 1'b0; mem_vec_i = 1'b1;
        mem_addr_i = 32'h200; mem_vdata_i = rnd256();
        step();
        vlsu_busy_i = 1'b1;
        step();
        step();
        mem_valid_i = 1'b0;
        reset = 1'b1;
        #1;
        exp_rdata = 32'h0; exp_vrdata = 256'h0; exp_align = 1'b0; exp_tmo = 1'b0;
        chk("midrst_stall", stall_o, 1'b0);
        chk("midrst_req", vlsu_req_o, 1'b0);
        chk("midrst_cmd", {vlsu_write_o, vlsu_src_o, vlsu_addr_o, vlsu_sdata_o},
            {1'b0, 1'b0, 32'h0, 16'h0});
        chk("midrst_vdata", vlsu_vdata_o, 256'h0);
        chk_state("midrst");
        step();
        vlsu_busy_i = 1'b0;
        reset = 1'b0;
        step();
        run_txn("post_rst", 1'b0, 1'b0, 32'h44, 16'h0, 256'h0, 0, 16'h0C0D, 256'h0, 1'b0);

        // Random transactions
        for (int n = 0; n < 40; n++) begin
            logic        wr, vec, fol;
            logic [31:0] a;
            vec = 1'($urandom);
            wr  = 1'($urandom);
            a   = $urandom;
            if (vec && $urandom_range(0, 5) != 0) a[4:0] = 5'd0;
            fol = 1'($urandom);
            run_txn("rnd", wr, vec, a, 16'($urandom), rnd256(), int'($urandom_range(0, 10)),
                    16'($urandom), rnd256(), fol);
            if (!fol) begin
                #1;
                chk("rnd_idle_stall", stall_o, 1'b0);
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
